// File: rtl/ex3_bcd_decoder.sv
// ex3_bcd_decoder: serial Excess-3 to BCD decoder.
// Accepts one Excess-3 digit per handshake and converts it to BCD. Digits are
// packed right-aligned into a multi-digit word, with the newest digit in
// bits [3:0]. A completed word is presented on a valid/ready output and held
// until the consumer takes it. Illegal codes are stored as nibble 4'hF and set
// a per-word sticky error flag.
module ex3_bcd_decoder #(
  parameter  int DIGITS = 4,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_ex3,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [CW-1:0]         out_count,
  output logic                  out_err
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t               state, state_next;
  logic [4*DIGITS-1:0]  sh, sh_shift;
  logic [CW-1:0]        cnt, cnt_inc;
  logic                 err, err_acc;
  logic                 accept, legal, close;
  logic [3:0]           digit;

  // Decode the incoming digit, form the next packed value and choose the next state.
  // NOTE: every signal gets a default at the top of the block so no path leaves
  // it unassigned; that is what keeps this combinational block latch-free.
  always_comb begin
    state_next = state;
    in_ready   = (state == COLLECT) & ~rst;
    out_valid  = (state == HOLD);
    accept     = in_valid & in_ready;

    legal = (in_ex3 >= 4'h3) && (in_ex3 <= 4'hC);
    digit = legal ? (in_ex3 - 4'd3) : 4'hF;

    // Shift left by one nibble and drop the new digit into the bottom.
    // Written this way so DIGITS = 1 needs no special-cased slice.
    sh_shift       = sh << 4;
    sh_shift[3:0]  = digit;
    cnt_inc        = cnt + 1'b1;
    err_acc        = err | ~legal;

    // The DIGITS-th digit closes the word even without in_last.
    close = accept & (in_last | (cnt_inc == CW'(DIGITS)));

    case (state)
      COLLECT: if (close)     state_next = HOLD;
      HOLD:    if (out_ready) state_next = COLLECT;
      default:                state_next = COLLECT;
    endcase
  end

  // State, packing registers and held output word.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset too, not just control, because the
      // outputs must read as zero during and after reset and a partial word
      // must not leak into the next one.
      state     <= COLLECT;
      sh        <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      out_bcd   <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (close) begin
          out_bcd   <= sh_shift;
          out_count <= cnt_inc;
          out_err   <= err_acc;
          sh        <= '0;
          cnt       <= '0;
          err       <= 1'b0;
        end else begin
          sh  <= sh_shift;
          cnt <= cnt_inc;
          err <= err_acc;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex3_bcd_decoder.sv
// tb_ex3_bcd_decoder: directed stimulus for ex3_bcd_decoder. A word-level
// reference model predicts handshake and output values, a compare process
// checks them every cycle, and the directed sequences also pin literal words.
module tb_ex3_bcd_decoder;

  localparam int DIGITS = 4;
  localparam int CW     = $clog2(DIGITS + 1);
  localparam int BW     = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_ex3 = 4'h0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_bcd;
  logic [CW-1:0] out_count;
  logic          out_err;

  int checks = 0;
  int errors = 0;

  ex3_bcd_decoder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ex3    (in_ex3),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_count (out_count),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Excess-3 meaning of a code: value minus three when legal, 15 otherwise.
  function automatic int ex3_value(input logic [3:0] code);
    if (code >= 3 && code <= 12) return int'(code) - 3;
    return 15;
  endfunction

  function automatic bit ex3_illegal(input logic [3:0] code);
    return (code < 3) || (code > 12);
  endfunction

  // Reference model: a word being built as a number in base 16, its digit
  // count and error flag, plus the word last delivered to the consumer.
  logic          m_hold  = 1'b0;
  logic          m_fresh = 1'b1;
  logic [31:0]   m_word  = '0;
  int            m_digits = 0;
  logic          m_werr  = 1'b0;
  logic [31:0]   exp_bcd = '0;
  int            exp_cnt = 0;
  logic          exp_err = 1'b0;
  logic          mon_en  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_hold   <= 1'b0;
      m_fresh  <= 1'b1;
      m_word   <= '0;
      m_digits <= 0;
      m_werr   <= 1'b0;
      exp_bcd  <= '0;
      exp_cnt  <= 0;
      exp_err  <= 1'b0;
    end else if (m_hold) begin
      if (out_ready) m_hold <= 1'b0;
    end else if (in_valid) begin
      if (in_last || (m_digits + 1 == DIGITS)) begin
        exp_bcd  <= m_word * 16 + 32'(ex3_value(in_ex3));
        exp_cnt  <= m_digits + 1;
        exp_err  <= m_werr | ex3_illegal(in_ex3);
        m_hold   <= 1'b1;
        m_fresh  <= 1'b0;
        m_word   <= '0;
        m_digits <= 0;
        m_werr   <= 1'b0;
      end else begin
        m_word   <= m_word * 16 + 32'(ex3_value(in_ex3));
        m_digits <= m_digits + 1;
        m_werr   <= m_werr | ex3_illegal(in_ex3);
      end
    end
  end

  // Compare process: handshake every cycle, data whenever it is defined.
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", 32'(in_ready), 32'(!m_hold && !rst));
      check("out_valid", 32'(out_valid), 32'(m_hold));
      if (m_hold || m_fresh) begin
        check("out_bcd", 32'(out_bcd), exp_bcd);
        check("out_count", 32'(out_count), 32'(exp_cnt));
        check("out_err", 32'(out_err), 32'(exp_err));
      end
    end
  end

  // Present a digit and hold it until accepted; returns just after the
  // accepting edge with in_valid still asserted.
  task automatic send(input logic [3:0] code, input logic last);
    bit done = 0;
    in_valid = 1'b1;
    in_ex3   = code;
    in_last  = last;
    for (int k = 0; k < 40 && !done; k++) begin
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for out_valid, then pin the held word against literal values.
  task automatic expect_word(input string name, input logic [BW-1:0] bcd,
                             input int cnt, input logic err);
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check({name, "_valid"}, 32'(seen), 32'd1);
    check({name, "_bcd"}, 32'(out_bcd), 32'(bcd));
    check({name, "_count"}, 32'(out_count), 32'(cnt));
    check({name, "_err"}, 32'(out_err), 32'(err));
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_bcd", 32'(out_bcd), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Code sweep: one single-digit word per code.
    for (int c = 0; c < 16; c++) begin
      logic [3:0] code;
      code = 4'(c);
      send(code, 1'b1);
      idle();
      expect_word("sweep", (c >= 3 && c <= 12) ? BW'(c - 3) : BW'(4'hF), 1,
                  (c < 3 || c > 12));
    end

    // Full word closed by the digit count, streamed back to back.
    send(4'h7, 1'b0);
    send(4'h8, 1'b0);
    send(4'h9, 1'b0);
    send(4'hA, 1'b0);
    idle();
    @(negedge clk);
    check("full_valid_next_cycle", 32'(out_valid), 32'd1);
    check("full_bcd", 32'(out_bcd), 32'h4567);
    check("full_count", 32'(out_count), 32'd4);
    check("full_err", 32'(out_err), 32'd0);

    // Short word, then a clean next word.
    send(4'hC, 1'b0);
    send(4'h3, 1'b1);
    idle();
    expect_word("short", 16'h0090, 2, 1'b0);
    send(4'h4, 1'b1);
    idle();
    expect_word("short_next", 16'h0001, 1, 1'b0);

    // Backpressure with a digit waiting on the input.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(4'h5, 1'b1);
    in_ex3 = 4'h6;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_bcd", 32'(out_bcd), 32'h0002);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(4'h6, 1'b1);
    idle();
    expect_word("bp_next", 16'h0003, 1, 1'b0);
    @(negedge clk);
    check("bp_no_duplicate", 32'(out_valid), 32'd0);

    // Illegal code in the middle of a word, then a legal word.
    send(4'h4, 1'b0);
    send(4'hE, 1'b0);
    send(4'h5, 1'b1);
    idle();
    expect_word("illegal", 16'h01F2, 3, 1'b1);
    send(4'h8, 1'b1);
    idle();
    expect_word("illegal_next", 16'h0005, 1, 1'b0);

    // Reset in the middle of a word.
    send(4'h4, 1'b0);
    send(4'h5, 1'b0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_bcd", 32'(out_bcd), 32'd0);
    check("midrst_out_count", 32'(out_count), 32'd0);
    check("midrst_out_err", 32'(out_err), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    send(4'h6, 1'b1);
    idle();
    expect_word("midrst_next", 16'h0003, 1, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex3_bcd_decoder.md
# ex3_bcd_decoder

Serial Excess-3 to BCD decoder: the receive-side counterpart of the BCD-to-Excess-3 encoder. It accepts one Excess-3 digit per handshake, checks it for legality, converts it to BCD and packs digits into a right-aligned multi-digit BCD word. The completed word goes out over a valid/ready interface and is held until the consumer takes it. It sits between a serial Excess-3 source (link, keypad scanner, display bus) and the BCD arithmetic/display logic.

## Interface
- DIGITS, 4, maximum digits per word (1..8)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  digit present on in_ex3
- in_ready  out  1  block can accept a digit this cycle
- in_ex3  in  4  Excess-3 coded digit
- in_last  in  1  qualifies the current digit as the final digit of the word
- out_valid  out  1  packed word available
- out_ready  in  1  consumer accepts the word this cycle
- out_bcd  out  4*DIGITS  packed BCD; most recent digit in bits [3:0]
- out_count  out  $clog2(DIGITS+1)  number of digits in the word (1..DIGITS)
- out_err  out  1  at least one illegal code in the word

## Operation
- States: COLLECT (reset state) and HOLD.
- in_ready = (state == COLLECT) & ~rst. Digit accepted when in_valid & in_ready.
- Decode of each accepted digit:
  - legal codes 4'h3..4'hC give digit = in_ex3 - 3 (4-bit)
  - illegal codes 4'h0..4'h2 and 4'hD..4'hF store nibble 4'hF and set the word error flag
- Packing: shift register sh <= {sh[4*DIGITS-5:0], digit}, so the first digit is most significant. Unused upper nibbles stay 0. Digit counter cnt increments per accepted digit.
- Word close: the accepted digit has in_last=1, or cnt reaches DIGITS (the DIGITS-th digit closes the word even with in_last=0). On close:
  - out_bcd, out_count and out_err load from the packed value
  - state -> HOLD
  - sh, cnt and the error flag clear for the next word
- HOLD: out_valid=1, and out_bcd, out_count and out_err are held stable. When out_valid & out_ready, go to COLLECT.
- in_valid is ignored in HOLD, because in_ready=0. No digit is lost or duplicated.
- Reset, including mid-word or in HOLD:
  - state=COLLECT
  - sh=0, cnt=0, error flag=0
  - out_valid=0, out_bcd=0, out_count=0, out_err=0
  - a partial word is discarded

## Timing
- Reset values: in_ready=0 while rst=1 and 1 in the first cycle after; out_valid=0; out_bcd=0; out_count=0; out_err=0.
- Latency: the closing digit is accepted at edge n, and out_valid=1 from edge n.
- The earliest next acceptance is the cycle after the out_valid & out_ready edge.
- Throughput: a k-digit word takes k+1 cycles minimum.
- in_ready is 0 in every cycle that out_valid is 1. Both are registered-state derived, with no combinational path from out_ready to in_ready.
- out_valid stays high until out_ready is seen. The consumer may hold out_ready high permanently.
- The error flag is sticky per word. An illegal digit that closes the word sets out_err for that same word.

## Test plan
- Code sweep: 16 single-digit words, each with in_last=1 and in_ex3=0..F.
  - 3..C give out_bcd=0..9, out_count=1, out_err=0
  - 0,1,2,D,E,F give out_bcd nibble F, out_err=1
- Full word: in_ex3 7,8,9,A with in_last=0 and DIGITS=4 -> out_bcd=16'h4567, out_count=4, out_err=0, one cycle after the 4th digit.
- Short word: in_ex3 C then 3 with in_last on the 2nd -> out_bcd=16'h0090, out_count=2. The next word starts clean.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 continuously.
  - outputs are stable and in_ready=0 throughout
  - after out_ready=1 the next digit is accepted exactly once
- Illegal mid-word: in_ex3 4, E, 5 with in_last on the 3rd -> out_bcd=16'h01F2, out_err=1. The following legal word has out_err=0.
- Reset mid-word: accept 2 digits, then pulse rst for 1 cycle.
  - all outputs are 0 during and after reset
  - a new 1-digit word of in_ex3 6 gives out_bcd=16'h0003, out_count=1
